// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch over a req/ack memory port plus IF/ID register with a one-entry skid buffer.
// Optional IF_PERF_CNT_EN adds fetch_cnt_o / bubble_cnt_o performance counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o,
`endif
  output logic        valid_o
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, pc4_q, pc4_d;
  logic [31:0] skid_instr_q, skid_pc4_q, pc_inc;
  logic valid_q, valid_d, kill_q, kill_d, skid_load, fetched;
  logic ack, take, kill_flush, occupied;
  assign pc_inc     = pc_q + 32'd4;
  assign ack        = (state_q == REQ) && imem_ack_i;
  assign take       = ack && !kill_q;
  assign kill_flush = flush_i || redirect_valid_i;
  assign occupied   = valid_q && stall_i;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    skid_load = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (take) begin
          pc_d = pc_inc;
          if (!kill_flush && occupied) begin
            state_d   = HOLD;
            skid_load = 1'b1;
          end
        end else if (ack) kill_d = 1'b0;
      end
      HOLD: state_d = (kill_flush || !stall_i) ? REQ : HOLD;
      default: state_d = IDLE;
    endcase
    // an outstanding request cannot be withdrawn, so its answer is marked for discard
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & ~32'h3;
      if (state_q == REQ && !imem_ack_i) kill_d = 1'b1;
    end
    addr_d = (state_q == REQ && !imem_ack_i) ? addr_q : pc_d;
  end
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    fetched = 1'b0;
    if (kill_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!occupied) begin
      if (state_q == HOLD) begin
        valid_d = 1'b1;
        instr_d = skid_instr_q;
        pc4_d   = skid_pc4_q;
        fetched = 1'b1;
      end else if (take) begin
        valid_d = 1'b1;
        instr_d = imem_rdata_i;
        pc4_d   = pc_inc;
        fetched = 1'b1;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'd0;
    end else if (skid_load) begin
      skid_instr_q <= imem_rdata_i;
      skid_pc4_q   <= pc_inc;
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_o  <= 32'd0;
      bubble_cnt_o <= 32'd0;
    end else begin
      fetch_cnt_o  <= fetch_cnt_o + {31'd0, fetched};
      bubble_cnt_o <= bubble_cnt_o + {31'd0, !valid_q};
    end
  end
`else
  logic unused_fetched;
  assign unused_fetched = fetched;
`endif
  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = addr_q;
  assign instr_o     = instr_q;
  assign pc_plus4_o  = pc4_q;
  assign valid_o     = valid_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed stimulus with a queue scoreboard of instructions handed to decode.
module tb_if_id_stage;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic stall_i = 1'b0, flush_i = 1'b0, redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic imem_req_o, imem_ack_i, valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_plus4_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, bubble_cnt_o, bub;
`endif
  int lat = 0, wcnt = 0, pass_cnt = 0, total_cnt = 0;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} exp_t;
  exp_t q[$];
  exp_t e;
  if_id_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_plus4_o(pc_plus4_o),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o),
`endif
    .valid_o(valid_o)
  );
  always #5 clk_i = ~clk_i;
  assign imem_ack_i   = imem_req_o && (wcnt >= lat);
  assign imem_rdata_i = imem_addr_o ^ 32'hDEAD_0000;
  always @(posedge clk_i) wcnt <= (imem_req_o && !imem_ack_i) ? wcnt + 1 : 0;
  function automatic logic [31:0] d(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  task automatic push(input logic [31:0] a, input logic [31:0] pc4);
    q.push_back({d(a), pc4});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask
  always @(negedge clk_i) begin
    if (rst_i && valid_o && !stall_i && !flush_i && !redirect_valid_i) begin
      total_cnt++;
      if (q.size() == 0) $display("FAIL unexpected_instr: got %h/%h expected none", instr_o, pc_plus4_o);
      else begin
        e = q.pop_front();
        if ({instr_o, pc_plus4_o} === e) pass_cnt++;
        else $display("FAIL sb_instr: got %h/%h expected %h/%h", instr_o, pc_plus4_o, e.instr, e.pc4);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd0);
    rst_i = 1'b1;
    push(32'd0, 32'd4); push(32'd4, 32'd8); push(32'd8, 32'd12);
    tick; // zero-wait streaming
    chk("c1_req", {31'd0, imem_req_o}, 32'd1);
    chk("c1_addr", imem_addr_o, 32'd0);
    chk("c1_valid", {31'd0, valid_o}, 32'd0);
    tick;
    chk("c2_addr", imem_addr_o, 32'd4);
    chk("c2_valid", {31'd0, valid_o}, 32'd1);
    chk("c2_pc4", pc_plus4_o, 32'd4);
    tick;
    chk("c3_addr", imem_addr_o, 32'd8);
    chk("c3_pc4", pc_plus4_o, 32'd8);
    stall_i = 1'b1;
    tick; // stall with word parked in skid
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("hold_instr4", instr_o, d(32'd4));
    tick;
    chk("hold_instr5", instr_o, d(32'd4));
    tick;
    chk("hold_instr6", instr_o, d(32'd4));
    chk("hold_valid6", {31'd0, valid_o}, 32'd1);
    tick;
    stall_i = 1'b0;
    lat = 3;
    push(32'd12, 32'd16);
    tick;
    chk("skid_instr", instr_o, d(32'd8));
    chk("skid_pc4", pc_plus4_o, 32'd12);
    chk("slow_req8", {31'd0, imem_req_o}, 32'd1);
    chk("slow_addr8", imem_addr_o, 32'd12);
    tick;
    chk("slow_addr9", imem_addr_o, 32'd12);
    chk("slow_valid9", {31'd0, valid_o}, 32'd0);
    tick;
    chk("slow_addr10", imem_addr_o, 32'd12);
    tick;
    chk("slow_valid11", {31'd0, valid_o}, 32'd0);
    tick;
    chk("slow_valid12", {31'd0, valid_o}, 32'd1);
    chk("slow_instr12", instr_o, d(32'd12));
    chk("slow_next_addr", imem_addr_o, 32'd16);
    push(32'h100, 32'h104);
    tick; // redirect while request to 0x10 pending
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick;
    redirect_valid_i = 1'b0;
    chk("kill_req", {31'd0, imem_req_o}, 32'd1);
    chk("kill_addr14", imem_addr_o, 32'd16);
    chk("kill_valid14", {31'd0, valid_o}, 32'd0);
    tick;
    chk("kill_addr15", imem_addr_o, 32'd16);
    lat = 0;
    tick;
    chk("kill_valid16", {31'd0, valid_o}, 32'd0);
    chk("redir_addr", imem_addr_o, 32'h100);
    tick;
    chk("redir_instr", instr_o, d(32'h100));
    chk("redir_pc4", pc_plus4_o, 32'h104);
    push(32'hFFFF_FFF8, 32'hFFFF_FFFC); push(32'hFFFF_FFFC, 32'd0);
    tick; // redirect with ack in the same cycle, toward the wrap point
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    tick;
    redirect_valid_i = 1'b0;
    chk("wrap_addr19", imem_addr_o, 32'hFFFF_FFF8);
    chk("wrap_valid19", {31'd0, valid_o}, 32'd0);
    tick;
    chk("wrap_addr20", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_pc4_20", pc_plus4_o, 32'hFFFF_FFFC);
    tick;
    chk("wrap_pc4_21", pc_plus4_o, 32'd0);
    chk("wrap_addr21", imem_addr_o, 32'd0);
    tick;
    chk("wrap_pc4_22", pc_plus4_o, 32'd4);
    stall_i = 1'b1;
    tick; // flush together with stall, skid occupied
    chk("fl_req", {31'd0, imem_req_o}, 32'd0);
    chk("fl_instr23", instr_o, d(32'd0));
    flush_i = 1'b1;
    tick;
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_instr", instr_o, 32'd0);
    chk("fl_req24", {31'd0, imem_req_o}, 32'd1);
    chk("fl_addr", imem_addr_o, 32'd8);
`ifdef IF_PERF_CNT_EN
    bub = bubble_cnt_o;
`endif
    flush_i = 1'b0;
    stall_i = 1'b0;
    push(32'd8, 32'd12);
    tick;
    chk("fl_resume", instr_o, d(32'd8));
    chk("fl_resume_valid", {31'd0, valid_o}, 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("perf_bubble", bubble_cnt_o, bub + 32'd1);
`endif
    @(negedge clk_i);
    #1;
    stall_i = 1'b1;
    repeat (2) tick;
    chk("sb_drained", q.size(), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rst2_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst2_valid", {31'd0, valid_o}, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
